// File: rtl/riscv_mon_pkg.sv
// Shared types for the checkpoint monitor: FSM state encoding and fail-cause codes.
package riscv_mon_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } mon_state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_TMO   = 2'd1;
  localparam logic [1:0] CAUSE_STALL = 2'd2;

endpackage

// File: rtl/riscv_checkpoint_monitor_if.sv
// Retirement stream, checkpoint table and verdict outputs of the checkpoint monitor.
// Handshake: retire_valid qualifies pc/leds for exactly one cycle; there is no ready, the monitor always accepts.
interface riscv_checkpoint_monitor_if
  import riscv_mon_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LED_W    = 5,
  parameter int NUM_CKPT = 4,
  parameter int TMO_W    = 16
) ();
  localparam int IDX_W = $clog2(NUM_CKPT + 1);

  logic                      retire_valid;
  logic [XLEN-1:0]           pc;
  logic [LED_W-1:0]          leds;
  logic [NUM_CKPT*XLEN-1:0]  ckpt_pc;
  logic [NUM_CKPT*LED_W-1:0] ckpt_leds;
  logic [TMO_W-1:0]          tmo_limit;
  logic [IDX_W-1:0]          ckpt_idx;
  logic                      done;
  logic                      pass;
  logic [1:0]                fail_cause;
  mon_state_e                state;

  modport master (
    output retire_valid, pc, leds, ckpt_pc, ckpt_leds, tmo_limit,
    input  ckpt_idx, done, pass, fail_cause, state
  );

  modport slave (
    input  retire_valid, pc, leds, ckpt_pc, ckpt_leds, tmo_limit,
    output ckpt_idx, done, pass, fail_cause, state
  );
endinterface

// File: rtl/riscv_mon_timer.sv
// Saturating up-counter with synchronous clear, used as the inter-checkpoint timeout.
module riscv_mon_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [TMO_W-1:0] count_o
);
  logic [TMO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {TMO_W{1'b1}})) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/riscv_checkpoint_monitor.sv
// Watches retired pcs/leds against an ordered checkpoint list and reports pass, timeout or stall.
// Stall detection is built only when RISCV_MON_STALL_DETECT_EN is defined.
module riscv_checkpoint_monitor
  import riscv_mon_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int LED_W       = 5,
  parameter int NUM_CKPT    = 4,
  parameter int TMO_W       = 16,
  parameter int STALL_LIMIT = 8
) (
  input logic                      clk,
  input logic                      reset,
  riscv_checkpoint_monitor_if.slave mon
);
  localparam int IDX_W = $clog2(NUM_CKPT + 1);

  if (NUM_CKPT < 1 || NUM_CKPT > 16 || STALL_LIMIT < 1) begin : g_bad_param
    $error("riscv_checkpoint_monitor: NUM_CKPT must be 1..16 and STALL_LIMIT >= 1");
  end

  mon_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       cause_q, cause_d;
  logic [XLEN-1:0]  cur_pc;
  logic [LED_W-1:0] cur_leds;
  logic [TMO_W-1:0] tmo_cnt;
  logic             match, tmo_hit, stall_hit;

  always_comb begin
    cur_pc   = '0;
    cur_leds = '0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_pc   = mon.ckpt_pc[k*XLEN +: XLEN];
        cur_leds = mon.ckpt_leds[k*LED_W +: LED_W];
      end
    end
  end

  assign match   = (state_q == RUN) && mon.retire_valid &&
                   (mon.pc == cur_pc) && (mon.leds == cur_leds);
  assign tmo_hit = (state_q == RUN) && (mon.tmo_limit != '0) && (tmo_cnt == mon.tmo_limit);

  riscv_mon_timer #(.TMO_W(TMO_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == RUN),
    .clr_i   (match),
    .count_o (tmo_cnt)
  );

`ifdef RISCV_MON_STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]    prev_pc_q, prev_pc_d;
  logic               same_pc;

  assign same_pc = mon.retire_valid && (mon.pc == prev_pc_q);
  // stall_cnt counts repeats, so a run of STALL_LIMIT identical pcs trips on its last retirement.
  assign stall_hit = (state_q == RUN) && same_pc && ((int'(stall_cnt_q) + 2) >= STALL_LIMIT);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    prev_pc_d   = prev_pc_q;
    if ((state_q == RUN) && mon.retire_valid) begin
      prev_pc_d = mon.pc;
      if (!same_pc)                         stall_cnt_d = '0;
      else if (int'(stall_cnt_q) < STALL_LIMIT) stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      prev_pc_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      prev_pc_q   <= prev_pc_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Priority: match, then stall, then timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    pass_d  = pass_q;
    cause_d = cause_q;
    if (match) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_W'(NUM_CKPT - 1)) begin
        state_d = PASS;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end
    end else if (stall_hit) begin
      state_d = FAIL;
      done_d  = 1'b1;
      cause_d = CAUSE_STALL;
    end else if (tmo_hit) begin
      state_d = FAIL;
      done_d  = 1'b1;
      cause_d = CAUSE_TMO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      idx_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cause_q <= cause_d;
    end
  end

  assign mon.ckpt_idx   = idx_q;
  assign mon.done       = done_q;
  assign mon.pass       = pass_q;
  assign mon.fail_cause = cause_q;
  assign mon.state      = state_q;
endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Bench for riscv_checkpoint_monitor with two checkpoints; stall cases follow RISCV_MON_STALL_DETECT_EN.
module tb_riscv_checkpoint_monitor;
  localparam int XLEN = 32, LED_W = 5, NUM_CKPT = 2, TMO_W = 16, STALL_LIMIT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_checkpoint_monitor_if #(.XLEN(XLEN), .LED_W(LED_W), .NUM_CKPT(NUM_CKPT), .TMO_W(TMO_W)) mon ();

  riscv_checkpoint_monitor #(
    .XLEN(XLEN), .LED_W(LED_W), .NUM_CKPT(NUM_CKPT), .TMO_W(TMO_W), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon)
  );

  // Expected word layout: {ckpt_idx[1:0], done, pass, fail_cause[1:0]}
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic [4:0]  leds;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [5:0] ew(input int idx, input bit d, input bit p, input int c);
    return {idx[1:0], d, p, c[1:0]};
  endfunction

  task automatic check_out(input string name);
    logic [5:0] exp, act;
    act = {mon.ckpt_idx, mon.done, mon.pass, mon.fail_cause};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, got idx=%0d done=%0b pass=%0b cause=%0d",
               name, act[5:4], act[3], act[2], act[1:0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got idx=%0d done=%0b pass=%0b cause=%0d, expected idx=%0d done=%0b pass=%0b cause=%0d",
                 name, act[5:4], act[3], act[2], act[1:0], exp[5:4], exp[3], exp[2], exp[1:0]);
      end
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] p, input logic [4:0] l,
                      input logic [5:0] exp, input string name);
    mon.retire_valid = rv;
    mon.pc           = p;
    mon.leds         = l;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic do_reset(input string name);
    mon.retire_valid = 1'b0;
    reset = 1'b1;
    exp_q.push_back(ew(0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_out(name);
    reset = 1'b0;
  endtask

  task automatic set_ckpts(input logic [31:0] p0, input logic [4:0] l0,
                           input logic [31:0] p1, input logic [4:0] l1);
    mon.ckpt_pc   = {p1, p0};
    mon.ckpt_leds = {l1, l0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mon.retire_valid = 1'b0;
    mon.pc           = '0;
    mon.leds         = '0;
    mon.tmo_limit    = '0;
    set_ckpts(32'h2c, 5'he, 32'h36, 5'h1);
    @(posedge clk);
    #1;

    do_reset("reset_state");

    // In-order run with near misses and ignored inputs after PASS.
    tbl[0] = '{1'b0, 32'h2c, 5'he, ew(0, 0, 0, 0)};
    tbl[1] = '{1'b1, 32'h2c, 5'hd, ew(0, 0, 0, 0)};
    tbl[2] = '{1'b1, 32'h30, 5'he, ew(0, 0, 0, 0)};
    tbl[3] = '{1'b1, 32'h2c, 5'he, ew(1, 0, 0, 0)};
    tbl[4] = '{1'b1, 32'h2c, 5'he, ew(1, 0, 0, 0)};
    tbl[5] = '{1'b1, 32'h36, 5'h0, ew(1, 0, 0, 0)};
    tbl[6] = '{1'b0, 32'h36, 5'h1, ew(1, 0, 0, 0)};
    tbl[7] = '{1'b1, 32'h36, 5'h1, ew(2, 1, 1, 0)};
    tbl[8] = '{1'b1, 32'h2c, 5'he, ew(2, 1, 1, 0)};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rv, tbl[i].pc, tbl[i].leds, tbl[i].exp, $sformatf("table[%0d]", i));
    end

    // Reset from PASS, then reset mid-run at ckpt_idx=1, then a clean run.
    do_reset("reset_from_pass");
    step(1'b1, 32'h2c, 5'he, ew(1, 0, 0, 0), "midrun_adv0");
    do_reset("reset_midrun");
    step(1'b1, 32'h2c, 5'he, ew(1, 0, 0, 0), "restart_adv0");
    step(1'b1, 32'h36, 5'h1, ew(2, 1, 1, 0), "restart_pass");

    // Identical consecutive checkpoints advance one per cycle.
    set_ckpts(32'h50, 5'h3, 32'h50, 5'h3);
    do_reset("reset_dup");
    step(1'b1, 32'h50, 5'h3, ew(1, 0, 0, 0), "dup_first");
    step(1'b1, 32'h50, 5'h3, ew(2, 1, 1, 0), "dup_second");

    // Timeout: fails on the 11th edge after reset release, then stays failed.
    set_ckpts(32'h2c, 5'he, 32'h36, 5'h1);
    mon.tmo_limit = 16'd10;
    do_reset("reset_tmo");
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 32'h0, 5'h0, (i == 11) ? ew(0, 1, 0, 1) : ew(0, 0, 0, 0),
           $sformatf("tmo_cycle%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h2c, 5'he, ew(0, 1, 0, 1), $sformatf("fail_sticky%0d", i));
    end

    // Match in the expiry cycle wins; the counter restarts from the match.
    do_reset("reset_from_fail");
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 32'h0, 5'h0, ew(0, 0, 0, 0), $sformatf("race_idle%0d", i));
    end
    step(1'b1, 32'h2c, 5'he, ew(1, 0, 0, 0), "race_match");
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 32'h0, 5'h0, (i == 11) ? ew(1, 1, 0, 1) : ew(1, 0, 0, 0),
           $sformatf("post_match_cycle%0d", i));
    end

    // tmo_limit=0 never times out.
    mon.tmo_limit = '0;
    do_reset("reset_notmo");
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 32'h0, 5'h0, ew(0, 0, 0, 0), $sformatf("notmo_cycle%0d", i));
    end

    // Repeated retirement of the same pc.
    do_reset("reset_stall");
    for (int i = 1; i <= 12; i++) begin
`ifdef RISCV_MON_STALL_DETECT_EN
      step(1'b1, 32'h40, 5'h0, (i >= 8) ? ew(0, 1, 0, 2) : ew(0, 0, 0, 0),
           $sformatf("stall_ret%0d", i));
`else
      step(1'b1, 32'h40, 5'h0, ew(0, 0, 0, 0), $sformatf("nostall_ret%0d", i));
`endif
    end

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_checkpoint_monitor.md
RISCV_CHECKPOINT_MONITOR -- requirements
Module: riscv_checkpoint_monitor

Interface
REQ-001 Parameter XLEN, default 32: width of pc and addr.
REQ-002 Parameter LED_W, default 5: width of leds.
REQ-003 Parameter NUM_CKPT, default 4, range 1..16: number of ordered checkpoints.
REQ-004 Parameter TMO_W, default 16: width of the timeout counter.
REQ-005 Parameter STALL_LIMIT, default 8: consecutive same-pc retirements that count as a stall.
REQ-006 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port retire_valid, input, 1: one instruction retires this cycle.
REQ-009 Port pc, input, XLEN: pc of the retiring instruction.
REQ-010 Port leds, input, LED_W: current LED register value.
REQ-011 Port ckpt_pc, input, NUM_CKPT*XLEN: flattened checkpoint pcs; entry k occupies bits [k*XLEN +: XLEN].
REQ-012 Port ckpt_leds, input, NUM_CKPT*LED_W: flattened expected leds per checkpoint.
REQ-013 Port tmo_limit, input, TMO_W: cycles allowed between checkpoints; 0 disables the timeout.
REQ-014 Port ckpt_idx, output, clog2(NUM_CKPT+1): index of the next checkpoint to match.
REQ-015 Port done, output, 1: run has terminated.
REQ-016 Port pass, output, 1: all checkpoints matched.
REQ-017 Port fail_cause, output, 2: 0 none, 1 timeout, 2 stall, 3 reserved.

Function
REQ-018 The FSM SHALL have states RUN, PASS, FAIL; it enters RUN after reset.
REQ-019 In RUN, a checkpoint match SHALL be retire_valid && pc==ckpt_pc[ckpt_idx] && leds==ckpt_leds[ckpt_idx]; ckpt_idx SHALL increment on the following edge.
REQ-020 The match at ckpt_idx==NUM_CKPT-1 SHALL move the FSM to PASS: done=1, pass=1 on the next cycle.
REQ-021 The timeout counter SHALL increment every RUN cycle, clear on each match, and saturate at its maximum value.
REQ-022 When tmo_limit!=0 and the counter equals tmo_limit with no match in that cycle, the FSM SHALL go to FAIL with fail_cause=1.
REQ-023 A match in the same cycle as timeout expiry SHALL win: advance, no fail.
REQ-024 At most one checkpoint SHALL advance per cycle, even if consecutive entries are identical.
REQ-025 PASS and FAIL SHALL be sticky until reset; inputs SHALL be ignored there.
REQ-026 The checkpoint check SHALL be evaluated only when retire_valid=1; leds changes without retire_valid SHALL have no effect.
REQ-027 Outputs SHALL be registered; a match or failure decision SHALL be visible exactly one cycle after the deciding cycle.

Reset
REQ-028 reset SHALL force state=RUN, ckpt_idx=0, done=0, pass=0, fail_cause=0, timeout counter=0, stall counter=0, prev_pc=0.
REQ-029 reset asserted mid-run or in PASS/FAIL SHALL restart monitoring on the first cycle after deassertion.

Configuration
REQ-030 With macro RISCV_MON_STALL_DETECT_EN defined, the block SHALL count consecutive retirements whose pc equals the previously retired pc.
REQ-031 With the macro defined: the count SHALL clear on a differing pc; reaching STALL_LIMIT in RUN SHALL move the FSM to FAIL with fail_cause=2.
REQ-032 With the macro defined: stall SHALL take priority over timeout in the same cycle, and a match in the same cycle SHALL win over both.
REQ-033 Without the macro, no stall logic SHALL exist and fail_cause SHALL never be 2.

Structure
REQ-034 Package riscv_mon_pkg SHALL hold the state enum (RUN/PASS/FAIL) and fail-cause constants (CAUSE_NONE, CAUSE_TMO, CAUSE_STALL).
REQ-035 The saturating, clearable timeout counter SHALL be sub-module riscv_mon_timer, parametrised by TMO_W.

Verification
REQ-036 NUM_CKPT=2, ckpt0={pc 0x2c, leds 0xe}, ckpt1={pc 0x36, leds 0x1}, driven in order -> ckpt_idx 0->1->2, then done=1, pass=1.
REQ-037 pc=0x2c retires with leds=0xd -> no advance; ckpt_idx stays 0.
REQ-038 tmo_limit=10, no match -> done=1, fail_cause=1, 11 cycles after reset deassertion; tmo_limit=0 -> never fails.
REQ-039 Match lands in the expiry cycle -> ckpt_idx advances, fail_cause stays 0.
REQ-040 Macro defined, STALL_LIMIT=8, pc=0x40 retired 8 times -> fail_cause=2; macro undefined -> no fail.
REQ-041 reset pulsed with ckpt_idx=1 -> ckpt_idx=0, done=0, and the run restarts cleanly.
